mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_W, default 64, data width in bits.
REQ-002 Parameter ADDR_W, default 32, address width in bits.
REQ-003 Parameter SB_DEPTH, default 4, store-buffer entries; power of two, 2 to 16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  pipeline presents a memory request.
REQ-007 req_wr  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 req_wdata  input  DATA_W  store data.
REQ-010 stall  output  1  combinational; pipeline holds the request stable while 1.
REQ-011 ld_valid  output  1  registered; one-cycle pulse, load result present.
REQ-012 ld_data  output  DATA_W  registered load result.
REQ-013 mem_en  output  1  memory request active.
REQ-014 mem_wr_en  output  1  1 = write request.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_ack  input  1  memory completes the current request this cycle; any latency of 1 or more cycles.
REQ-018 mem_rdata  input  DATA_W  read data, valid when mem_ack=1 on a read.
REQ-019 sb_count  output  $clog2(SB_DEPTH+1)  store-buffer occupancy.

Function
REQ-020 The FIFO store buffer holds {addr, data}. A store is accepted when req_valid=1, req_wr=1 and the buffer is not full: stall=0 and the entry is enqueued at the edge.
REQ-021 A store to a full buffer gets stall=1, even when a pop occurs in the same cycle.
REQ-022 On a simultaneous enqueue and pop, sb_count is unchanged.
REQ-023 A load matching one or more buffer addresses (exact ADDR_W compare) is a hit: stall=0, ld_data = youngest matching entry's data and ld_valid=1 the next cycle; no memory access.
REQ-024 A load miss gets stall=1 until its consume cycle, which is the cycle mem_ack=1 in state LOAD; stall=0 in that cycle; ld_data=mem_rdata and ld_valid=1 the next cycle.
REQ-025 The FSM has states IDLE, LOAD and DRAIN.
REQ-026 IDLE -> LOAD on a load miss present.
REQ-027 IDLE -> DRAIN when the buffer is non-empty and no load miss is present.
REQ-028 LOAD and DRAIN exit on mem_ack, applying the same IDLE priority in the ack cycle: load miss first, then non-empty buffer to DRAIN, else IDLE.
REQ-029 In LOAD: mem_en=1, mem_wr_en=0, mem_addr = latched load address.
REQ-030 In DRAIN: mem_en=1, mem_wr_en=1, mem_addr/mem_wdata = head entry; head pops on mem_ack.
REQ-031 Outputs to memory are registered and stable from request until ack; a request in flight is never withdrawn.
REQ-032 A draining entry stays forwardable until popped.
REQ-033 A load miss arriving during DRAIN stalls until the store acks, then enters LOAD ahead of remaining stores. Loads may bypass buffered stores to different addresses.
REQ-034 mem_en=0 and mem_wr_en=0 in IDLE.
REQ-035 ld_valid is 0 in every cycle without a completing load; ld_data holds its last value.
REQ-036 req_valid=0 gives stall=0.

Reset
REQ-037 On reset assertion, immediately and regardless of clk: FSM=IDLE, buffer emptied (sb_count=0), mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, ld_valid=0, ld_data=0.
REQ-038 Reset mid-transaction abandons any in-flight load or store; mem_ack arriving after reset deasserts is ignored in IDLE.

Verification
REQ-039 Store A=0x10/D=0x11, then load 0x10 -> ld_valid one cycle later, ld_data=0x11, no mem_en=1 cycles used for the load.
REQ-040 Stores 0x20/0x1, then 0x20/0x2, mem_ack held 0; load 0x20 -> ld_data=0x2 (youngest entry).
REQ-041 Four stores with SB_DEPTH=4, mem_ack=0, then a fifth store -> stall=1, sb_count=4; one mem_ack -> sb_count=3 next cycle, fifth store accepted.
REQ-042 Load miss 0x40, mem_ack after 3 cycles with rdata=0xAB -> stall=1 through the ack cycle-1, ld_valid=1 with ld_data=0xAB the cycle after the ack.
REQ-043 Load miss while DRAIN is in flight -> store completes first, then mem_wr_en=0 read of the load address before the next store.
REQ-044 Reset asserted during LOAD with two buffered stores -> mem_en=0 asynchronously, sb_count=0, ld_valid stays 0.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: FIFO store buffer with youngest-entry load forwarding, a single
// outstanding memory request, and registered memory-side outputs.
module mem_lsu #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_wr,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          stall,
  output logic                          ld_valid,
  output logic [DATA_W-1:0]             ld_data,
  output logic                          mem_en,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count
);

  localparam int unsigned CW = $clog2(SB_DEPTH + 1);
  localparam int unsigned PW = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q, head_idx;
  logic [CW-1:0]     cnt_q, cnt_d, remain;

  logic              is_load, hit, ld_hit, load_done, miss_new, full, enq, pop, decide;
  logic [DATA_W-1:0] fwd_data, head_data;
  logic [ADDR_W-1:0] head_addr;

  assign sb_count = cnt_q;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (CW'(i) < cnt_q && sb_addr_q[rd_ptr_q + PW'(i)] == req_addr) begin
        hit      = 1'b1;
        fwd_data = sb_data_q[rd_ptr_q + PW'(i)];
      end
    end
  end

  always_comb begin
    is_load   = req_valid && !req_wr;
    ld_hit    = is_load && hit;
    load_done = (state_q == StLoad) && mem_ack;
    // The held load in LOAD is already being served, so it never counts as a new miss.
    miss_new  = is_load && !hit && (state_q != StLoad);
    full      = (cnt_q == CW'(SB_DEPTH));
    enq       = req_valid && req_wr && !full;
    pop       = (state_q == StDrain) && mem_ack;
    stall     = req_valid && (req_wr ? full : (!hit && !load_done));
    cnt_d     = cnt_q + CW'(enq) - CW'(pop);
    decide    = (state_q == StIdle) || mem_ack;

    state_d = state_q;
    if (decide) begin
      if (miss_new)            state_d = StLoad;
      else if (cnt_d != '0)    state_d = StDrain;
      else                     state_d = StIdle;
    end

    // Next head after this edge; falls back to the incoming store when the buffer empties.
    head_idx = rd_ptr_q + PW'(pop);
    remain   = cnt_q - CW'(pop);
    if (remain != '0) begin
      head_addr = sb_addr_q[head_idx];
      head_data = sb_data_q[head_idx];
    end else begin
      head_addr = req_addr;
      head_data = req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enq) begin
        sb_addr_q[wr_ptr_q] <= req_addr;
        sb_data_q[wr_ptr_q] <= req_wdata;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      ld_valid <= ld_hit || load_done;
      if (ld_hit)         ld_data <= fwd_data;
      else if (load_done) ld_data <= mem_rdata;

      // Memory outputs only change when a request starts or finishes.
      if (decide) begin
        unique case (state_d)
          StLoad: begin
            mem_en    <= 1'b1;
            mem_wr_en <= 1'b0;
            mem_addr  <= req_addr;
          end
          StDrain: begin
            mem_en    <= 1'b1;
            mem_wr_en <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
          end
          default: begin
            mem_en    <= 1'b0;
            mem_wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: table-driven request stream against a memory model,
// plus hand-driven sequences for forwarding, full buffer, miss latency, ordering, reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wr;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall, ld_valid;
  logic [63:0] ld_data;
  logic        mem_en, mem_wr_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [2:0]  sb_count;

  mem_lsu #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .ld_valid(ld_valid),
    .ld_data(ld_data), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic [63:0] d;} st_t;
  typedef struct {bit wr; logic [31:0] addr; logic [63:0] wdata; logic [63:0] exp;} vec_t;

  int          nchk = 0;
  int          nerr = 0;
  bit          auto_mode = 1'b0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic [63:0] ld_q [$];
  st_t         st_q [$];
  logic [63:0] mem_model [logic [31:0]];
  vec_t        vecs [14];

  function automatic logic [63:0] rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {32'hC0DE0000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Advance one clock; run the memory responder and the load-result scoreboard.
  task automatic step();
    st_t s;
    @(posedge clk);
    #1;
    if (auto_mode) begin
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_en) begin
        if (wait_cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_wr_en) begin
            if (st_q.size() == 0) begin
              nchk++; nerr++;
              $display("FAIL store_order: write %h to %h, required no write", mem_wdata, mem_addr);
            end else begin
              s = st_q.pop_front();
              chk("store_addr", {32'h0, mem_addr}, {32'h0, s.a});
              chk("store_data", mem_wdata, s.d);
            end
            mem_model[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = rd(mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
    if (ld_valid) begin
      if (ld_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL ld_unexpected: ld_valid=1 ld_data=%h, required no pulse", ld_data);
      end else begin
        chk("ld_data", ld_data, ld_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    wait_cnt  = 0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                       input logic [63:0] exp, input string tag);
    int cyc;
    st_t s;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    if (!wr) ld_q.push_back(exp);
    for (cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (!stall) break;
      step();
    end
    if (cyc == 200) begin
      nchk++; nerr++;
      $display("FAIL %s_timeout: stall=1 after 200 cycles, required 0", tag);
      if (!wr) void'(ld_q.pop_back());
    end else begin
      if (wr && auto_mode) begin
        s.a = addr;
        s.d = data;
        st_q.push_back(s);
      end
      step();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    vecs[0]  = '{1'b1, 32'h100, 64'h1111, 64'h0};
    vecs[1]  = '{1'b1, 32'h108, 64'h2222, 64'h0};
    vecs[2]  = '{1'b0, 32'h100, 64'h0,    64'h1111};
    vecs[3]  = '{1'b0, 32'h200, 64'h0,    64'hC0DE0000_00000200};
    vecs[4]  = '{1'b1, 32'h100, 64'h3333, 64'h0};
    vecs[5]  = '{1'b0, 32'h100, 64'h0,    64'h3333};
    vecs[6]  = '{1'b1, 32'h300, 64'h4444, 64'h0};
    vecs[7]  = '{1'b1, 32'h300, 64'h5555, 64'h0};
    vecs[8]  = '{1'b0, 32'h300, 64'h0,    64'h5555};
    vecs[9]  = '{1'b0, 32'h108, 64'h0,    64'h2222};
    vecs[10] = '{1'b1, 32'h500, 64'hAAAA, 64'h0};
    vecs[11] = '{1'b1, 32'h508, 64'hBBBB, 64'h0};
    vecs[12] = '{1'b0, 32'h508, 64'h0,    64'hBBBB};
    vecs[13] = '{1'b0, 32'h50C, 64'h0,    64'hC0DE0000_0000050C};

    // Reset state.
    step();
    chk("rst_mem_en", {63'h0, mem_en}, 64'h0);
    chk("rst_mem_wr_en", {63'h0, mem_wr_en}, 64'h0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_sb_count", {61'h0, sb_count}, 64'h0);
    chk("rst_ld_valid", {63'h0, ld_valid}, 64'h0);
    chk("rst_ld_data", ld_data, 64'h0);
    reset = 1'b0;
    #1;
    chk("idle_no_req_stall", {63'h0, stall}, 64'h0);

    // Table-driven stream against the memory model, two ack latencies.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      auto_mode = 1'b1;
      lat = p * 3;
      for (int i = 0; i < 14; i++)
        issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
      for (int c = 0; c < 300; c++) begin
        if (sb_count == 0 && !mem_en && !mem_ack) break;
        step();
      end
      chk("drain_sb_count", {61'h0, sb_count}, 64'h0);
      chk("drain_mem_en", {63'h0, mem_en}, 64'h0);
      chk("drain_st_left", 64'(st_q.size()), 64'h0);
    end
    auto_mode = 1'b0;

    // Forward from a single buffered store, no read issued.
    do_reset();
    issue(1'b1, 32'h10, 64'h11, 64'h0, "fwd_st");
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10;
    #1;
    chk("fwd_stall", {63'h0, stall}, 64'h0);
    req_valid = 1'b0;
    issue(1'b0, 32'h10, 64'h0, 64'h11, "fwd_ld");
    chk("fwd_mem_wr_en", {63'h0, mem_wr_en}, 64'h1);
    chk("fwd_mem_addr", {32'h0, mem_addr}, 64'h10);

    // Youngest match, then full buffer with a pop in the same cycle.
    do_reset();
    issue(1'b1, 32'h20, 64'h1, 64'h0, "yng_st0");
    issue(1'b1, 32'h20, 64'h2, 64'h0, "yng_st1");
    issue(1'b0, 32'h20, 64'h0, 64'h2, "yng_ld");
    issue(1'b1, 32'h30, 64'h3, 64'h0, "full_st2");
    issue(1'b1, 32'h38, 64'h4, 64'h0, "full_st3");
    chk("full_count", {61'h0, sb_count}, 64'h4);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h50; req_wdata = 64'h5;
    #1;
    chk("full_stall", {63'h0, stall}, 64'h1);
    chk("drain_head_addr", {32'h0, mem_addr}, 64'h20);
    chk("drain_head_data", mem_wdata, 64'h1);
    mem_ack = 1'b1;
    #1;
    chk("full_stall_pop", {63'h0, stall}, 64'h1);
    step();
    mem_ack = 1'b0;
    #1;
    chk("pop_count", {61'h0, sb_count}, 64'h3);
    chk("pop_stall", {63'h0, stall}, 64'h0);
    chk("next_head_data", mem_wdata, 64'h2);
    step();
    req_valid = 1'b0;
    chk("fifth_count", {61'h0, sb_count}, 64'h4);

    // Load miss with three-cycle memory latency.
    do_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h40;
    #1;
    chk("miss_stall0", {63'h0, stall}, 64'h1);
    step();
    chk("miss_mem_en", {63'h0, mem_en}, 64'h1);
    chk("miss_mem_wr_en", {63'h0, mem_wr_en}, 64'h0);
    chk("miss_mem_addr", {32'h0, mem_addr}, 64'h40);
    step();
    step();
    chk("miss_stall_wait", {63'h0, stall}, 64'h1);
    mem_ack = 1'b1; mem_rdata = 64'hAB;
    #1;
    chk("miss_stall_ack", {63'h0, stall}, 64'h0);
    ld_q.push_back(64'hAB);
    step();
    mem_ack = 1'b0; req_valid = 1'b0;
    chk("miss_ld_valid", {63'h0, ld_valid}, 64'h1);
    chk("miss_idle_mem_en", {63'h0, mem_en}, 64'h0);
    step();
    chk("miss_pulse_once", {63'h0, ld_valid}, 64'h0);
    chk("miss_ld_hold", ld_data, 64'hAB);

    // Load miss behind an in-flight store overtakes the remaining store.
    do_reset();
    issue(1'b1, 32'h60, 64'h6, 64'h0, "ord_st0");
    issue(1'b1, 32'h68, 64'h7, 64'h0, "ord_st1");
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h70;
    #1;
    chk("ord_stall", {63'h0, stall}, 64'h1);
    step();
    mem_ack = 1'b1;
    #1;
    chk("ord_stall_st_ack", {63'h0, stall}, 64'h1);
    step();
    mem_ack = 1'b0;
    chk("ord_rd_en", {63'h0, mem_en}, 64'h1);
    chk("ord_rd_wr_en", {63'h0, mem_wr_en}, 64'h0);
    chk("ord_rd_addr", {32'h0, mem_addr}, 64'h70);
    chk("ord_count", {61'h0, sb_count}, 64'h1);
    mem_ack = 1'b1; mem_rdata = 64'h77;
    ld_q.push_back(64'h77);
    #1;
    chk("ord_ld_stall", {63'h0, stall}, 64'h0);
    step();
    mem_ack = 1'b0; req_valid = 1'b0;
    chk("ord_next_wr_en", {63'h0, mem_wr_en}, 64'h1);
    chk("ord_next_addr", {32'h0, mem_addr}, 64'h68);
    chk("ord_next_data", mem_wdata, 64'h7);

    // Asynchronous reset during LOAD with two buffered stores.
    do_reset();
    issue(1'b1, 32'h80, 64'h8, 64'h0, "rst_st0");
    issue(1'b1, 32'h88, 64'h9, 64'h0, "rst_st1");
    issue(1'b1, 32'h90, 64'hA, 64'h0, "rst_st2");
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'hA0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("pre_rst_count", {61'h0, sb_count}, 64'h2);
    chk("pre_rst_rd", {62'h0, mem_en, mem_wr_en}, 64'h2);
    #2;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    chk("arst_mem_en", {63'h0, mem_en}, 64'h0);
    chk("arst_count", {61'h0, sb_count}, 64'h0);
    chk("arst_ld_valid", {63'h0, ld_valid}, 64'h0);
    chk("arst_mem_addr", {32'h0, mem_addr}, 64'h0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("stale_ack_ld_valid", {63'h0, ld_valid}, 64'h0);
    chk("stale_ack_mem_en", {63'h0, mem_en}, 64'h0);
    step();

    chk("ld_pending", 64'(ld_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
